// File: rtl/cell_comm_link_stats_if.sv
// Signal bundle for the per-link RX statistics engine: RX observation inputs,
// snapshot/readout control and status outputs.
interface cell_comm_link_stats_if #(
    parameter int NUM_LINKS  = 2,
    parameter int DATA_WIDTH = 32
);
    localparam int SEL_W = $clog2(NUM_LINKS) + 2;

    logic [NUM_LINKS-1:0]  rxTvalid;
    logic [NUM_LINKS-1:0]  rxTlast;
    logic [NUM_LINKS-1:0]  rxCRCvalid;
    logic [NUM_LINKS-1:0]  rxCRCpass;
    logic [NUM_LINKS-1:0]  channelUp;
    logic                  snapStrobe;
    logic [SEL_W-1:0]      readSel;
    logic [DATA_WIDTH-1:0] readData;
    logic [NUM_LINKS-1:0]  staleLinks;
    logic [NUM_LINKS-1:0]  faultSeen;

    modport master (
        output rxTvalid, rxTlast, rxCRCvalid, rxCRCpass, channelUp, snapStrobe, readSel,
        input  readData, staleLinks, faultSeen
    );
    modport slave (
        input  rxTvalid, rxTlast, rxCRCvalid, rxCRCpass, channelUp, snapStrobe, readSel,
        output readData, staleLinks, faultSeen
    );
endinterface

// File: rtl/cell_comm_link_stats.sv
// Per-link RX frame statistics: saturating good/crc/length/linkDown counters,
// stale-link watchdog, atomic snapshot to shadow registers, registered readout.
module cell_comm_link_lane #(
    parameter int CW  = 16,
    parameter int FW  = 16,
    parameter int TO  = 125000,
    parameter int CLR = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tvalid,
    input  logic               tlast,
    input  logic               crc_valid,
    input  logic               crc_pass,
    input  logic               chan_up,
    input  logic               snap,
    output logic [3:0][CW-1:0] shadow,
    output logic               stale,
    output logic               fault
);
    localparam int WC_W = $clog2(FW + 2);
    localparam int WD_W = $clog2(TO + 1);

    typedef enum logic [1:0] {IDLE, IN_FRAME, DISCARD} state_t;

    state_t            state, state_nxt;
    logic [WC_W-1:0]   wcnt, wcnt_nxt, wcnt_inc, total;
    logic [WD_W-1:0]   wd;
    logic [3:0][CW-1:0] live;
    logic [3:0]        inc;
    logic              up_q, rose_q, rise, fall, done, crc_fail;

    assign rise     = chan_up & ~up_q;
    assign fall     = ~chan_up & up_q;
    assign wcnt_inc = (wcnt == WC_W'(FW + 1)) ? wcnt : wcnt + 1'b1;
    assign crc_fail = crc_valid & ~crc_pass;

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        done      = 1'b0;
        total     = '0;
        if (!chan_up) begin
            state_nxt = IDLE;
            wcnt_nxt  = '0;
        end else if (tvalid) begin
            case (state)
                IDLE: begin
                    if (tlast) begin
                        done  = 1'b1;
                        total = WC_W'(1);
                    end else if (rise || rose_q) begin
                        // first word right after link-up is the tail of an unseen frame
                        state_nxt = DISCARD;
                    end else begin
                        state_nxt = IN_FRAME;
                        wcnt_nxt  = WC_W'(1);
                    end
                end
                IN_FRAME: begin
                    wcnt_nxt = wcnt_inc;
                    if (tlast) begin
                        done      = 1'b1;
                        total     = wcnt_inc;
                        state_nxt = IDLE;
                        wcnt_nxt  = '0;
                    end
                end
                DISCARD: if (tlast) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign inc[0] = done & ~crc_fail & (total == WC_W'(FW));
    assign inc[1] = done & crc_fail;
    assign inc[2] = done & ~crc_fail & (total != WC_W'(FW));
    assign inc[3] = fall;
    assign stale  = (wd == WD_W'(TO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wcnt   <= '0;
            up_q   <= 1'b0;
            rose_q <= 1'b0;
            wd     <= '0;
            fault  <= 1'b0;
            live   <= '0;
            shadow <= '0;
        end else begin
            state  <= state_nxt;
            wcnt   <= wcnt_nxt;
            up_q   <= chan_up;
            rose_q <= rise;
            if (!chan_up || done)     wd <= '0;
            else if (!stale)          wd <= wd + 1'b1;
            if (inc[1] || inc[2])     fault <= 1'b1;
            else if (snap)            fault <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (snap && CLR != 0)                 live[k] <= inc[k] ? CW'(1) : '0;
                else if (inc[k] && live[k] != '1)     live[k] <= live[k] + 1'b1;
            end
            if (snap) shadow <= live;
        end
    end
endmodule

module cell_comm_link_stats #(
    parameter int NUM_LINKS      = 2,
    parameter int COUNTER_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int FRAME_WORDS    = 16,
    parameter int TIMEOUT_CYCLES = 125000,
    parameter int CLEAR_ON_SNAP  = 1
) (
    input  logic                   sysClk,
    input  logic                   sysReset_n,
    cell_comm_link_stats_if.slave  bus
);
    localparam int SEL_W  = $clog2(NUM_LINKS) + 2;
    localparam int LINK_W = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;

    logic [NUM_LINKS-1:0][3:0][COUNTER_WIDTH-1:0] shadow;
    logic [SEL_W-1:0]  sel;
    logic [LINK_W-1:0] link_sel;

    assign sel = bus.readSel;

    if (NUM_LINKS > 1) begin : g_sel
        assign link_sel = sel[SEL_W-1:2];
    end else begin : g_sel_one
        assign link_sel = '0;
    end

    for (genvar i = 0; i < NUM_LINKS; i++) begin : g_lane
        cell_comm_link_lane #(
            .CW (COUNTER_WIDTH),
            .FW (FRAME_WORDS),
            .TO (TIMEOUT_CYCLES),
            .CLR(CLEAR_ON_SNAP)
        ) u_lane (
            .clk      (sysClk),
            .rst_n    (sysReset_n),
            .tvalid   (bus.rxTvalid[i]),
            .tlast    (bus.rxTlast[i]),
            .crc_valid(bus.rxCRCvalid[i]),
            .crc_pass (bus.rxCRCpass[i]),
            .chan_up  (bus.channelUp[i]),
            .snap     (bus.snapStrobe),
            .shadow   (shadow[i]),
            .stale    (bus.staleLinks[i]),
            .fault    (bus.faultSeen[i])
        );
    end

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n)                   bus.readData <= '0;
        else if (int'(link_sel) < NUM_LINKS) bus.readData <= DATA_WIDTH'(shadow[link_sel][sel[1:0]]);
        else                               bus.readData <= '0;
    end
endmodule

// File: tb/tb_cell_comm_link_stats.sv
// Directed bench for cell_comm_link_stats: table of single-frame vectors plus
// hand-written sequences for link-down, coincident snap, saturation, watchdog, reset.
module tb_cell_comm_link_stats;
    logic sysClk;
    logic sysReset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    cell_comm_link_stats_if #(.NUM_LINKS(2), .DATA_WIDTH(32)) bus ();

    cell_comm_link_stats #(
        .NUM_LINKS(2), .COUNTER_WIDTH(4), .DATA_WIDTH(32),
        .FRAME_WORDS(16), .TIMEOUT_CYCLES(100), .CLEAR_ON_SNAP(1)
    ) dut (
        .sysClk    (sysClk),
        .sysReset_n(sysReset_n),
        .bus       (bus)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    typedef struct {
        int link; int words; bit cv; bit cp;
        int fault; int good; int crc; int len;
    } vec_t;
    vec_t vecs[8];

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_frame(int link, int n, bit cv, bit cp, bit snap_last);
        for (int w = 1; w <= n; w++) begin
            bus.rxTvalid[link]   = 1'b1;
            bus.rxTlast[link]    = (w == n);
            bus.rxCRCvalid[link] = (w == n) & cv;
            bus.rxCRCpass[link]  = (w == n) & cp;
            bus.snapStrobe       = (w == n) & snap_last;
            tick();
        end
        bus.rxTvalid[link]   = 1'b0;
        bus.rxTlast[link]    = 1'b0;
        bus.rxCRCvalid[link] = 1'b0;
        bus.rxCRCpass[link]  = 1'b0;
        bus.snapStrobe       = 1'b0;
        tick();
    endtask

    task automatic snap();
        bus.snapStrobe = 1'b1;
        tick();
        bus.snapStrobe = 1'b0;
    endtask

    task automatic rd(int link, int cnt, output int val);
        bus.readSel = 3'((link << 2) | cnt);
        tick();
        val = int'(bus.readData);
    endtask

    initial begin
        int v, cyc;
        bit seen;

        vecs[0] = '{1, 16, 1, 1, 0, 1, 0, 0};
        vecs[1] = '{0, 16, 1, 0, 1, 0, 1, 0};
        vecs[2] = '{0, 15, 0, 0, 1, 0, 0, 1};
        vecs[3] = '{0, 17, 0, 0, 1, 0, 0, 1};
        vecs[4] = '{1,  1, 0, 0, 1, 0, 0, 1};
        vecs[5] = '{0, 16, 0, 0, 0, 1, 0, 0};
        vecs[6] = '{1, 20, 0, 0, 1, 0, 0, 1};
        vecs[7] = '{0, 15, 1, 0, 1, 0, 1, 0};

        bus.rxTvalid = '0; bus.rxTlast = '0; bus.rxCRCvalid = '0; bus.rxCRCpass = '0;
        bus.channelUp = 2'b11; bus.snapStrobe = 1'b0; bus.readSel = '0;
        sysReset_n = 1'b0;
        repeat (3) tick();
        check("reset_readData", int'(bus.readData), 0);
        check("reset_stale", int'(bus.staleLinks), 0);
        check("reset_fault", int'(bus.faultSeen), 0);
        sysReset_n = 1'b1;
        repeat (3) tick();

        // one frame per vector, snapshot, read back that link's four counters
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].link, vecs[i].words, vecs[i].cv, vecs[i].cp, 1'b0);
            check($sformatf("vec%0d_fault", i), int'(bus.faultSeen[vecs[i].link]), vecs[i].fault);
            snap();
            rd(vecs[i].link, 0, v); check($sformatf("vec%0d_good", i), v, vecs[i].good);
            rd(vecs[i].link, 1, v); check($sformatf("vec%0d_crc", i), v, vecs[i].crc);
            rd(vecs[i].link, 2, v); check($sformatf("vec%0d_len", i), v, vecs[i].len);
            rd(vecs[i].link, 3, v); check($sformatf("vec%0d_down", i), v, 0);
        end

        // three good frames on link 1
        snap();
        repeat (3) send_frame(1, 16, 1, 1, 1'b0);
        check("good3_fault", int'(bus.faultSeen), 0);
        snap();
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < 4; c++) begin
                rd(l, c, v);
                check($sformatf("good3_l%0d_c%0d", l, c), v, (l == 1 && c == 0) ? 3 : 0);
            end

        // link 0: crc fault, short frame, long frame
        send_frame(0, 16, 1, 0, 1'b0);
        send_frame(0, 15, 0, 0, 1'b0);
        send_frame(0, 17, 0, 0, 1'b0);
        check("mix_fault_set", int'(bus.faultSeen), 1);
        snap();
        rd(0, 1, v); check("mix_crc", v, 1);
        rd(0, 2, v); check("mix_len", v, 2);
        rd(0, 0, v); check("mix_good", v, 0);
        snap();
        check("mix_fault_clr", int'(bus.faultSeen), 0);

        // channel drop at word 8, traffic ignored while down, tail discarded after rise
        for (int w = 1; w <= 8; w++) begin bus.rxTvalid[0] = 1'b1; tick(); end
        bus.channelUp[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin bus.rxTlast[0] = (c == 2); tick(); end
        bus.rxTlast[0] = 1'b0;
        bus.channelUp[0] = 1'b1;
        for (int w = 1; w <= 4; w++) begin bus.rxTlast[0] = (w == 4); tick(); end
        bus.rxTvalid[0] = 1'b0; bus.rxTlast[0] = 1'b0;
        repeat (3) tick();
        send_frame(0, 16, 0, 0, 1'b0);
        snap();
        rd(0, 3, v); check("drop_down", v, 1);
        rd(0, 2, v); check("drop_len", v, 0);
        rd(0, 0, v); check("drop_good", v, 1);
        rd(0, 1, v); check("drop_crc", v, 0);

        // snap coincident with link 1 good-frame tlast
        snap();
        repeat (4) send_frame(1, 16, 1, 1, 1'b0);
        send_frame(1, 16, 1, 1, 1'b1);
        rd(1, 0, v); check("coinc_shadow", v, 4);
        snap();
        rd(1, 0, v); check("coinc_next", v, 1);

        // crc counter saturation at 15
        snap();
        repeat (20) send_frame(0, 2, 1, 0, 1'b0);
        snap();
        rd(0, 1, v); check("sat_crc", v, 15);
        send_frame(0, 2, 1, 0, 1'b0);

        // async reset mid-frame
        for (int w = 1; w <= 3; w++) begin bus.rxTvalid[0] = 1'b1; tick(); end
        #3;
        check("prerst_readData", int'(bus.readData), 15);
        check("prerst_fault", int'(bus.faultSeen), 1);
        sysReset_n = 1'b0;
        #1;
        check("rst_readData", int'(bus.readData), 0);
        check("rst_stale", int'(bus.staleLinks), 0);
        check("rst_fault", int'(bus.faultSeen), 0);

        // watchdog from reset release with no traffic
        bus.rxTvalid = '0; bus.rxTlast = '0; bus.channelUp = 2'b11;
        tick();
        sysReset_n = 1'b1;
        cyc = 0; seen = 1'b0;
        for (int c = 1; c <= 200 && !seen; c++) begin
            tick();
            if (bus.staleLinks[0]) begin seen = 1'b1; cyc = c; end
        end
        check("stale_rise_cycle", cyc, 100);
        check("stale_both", int'(bus.staleLinks), 3);
        for (int w = 1; w <= 15; w++) begin bus.rxTvalid[0] = 1'b1; tick(); end
        check("stale_hold", int'(bus.staleLinks[0]), 1);
        bus.rxTlast[0] = 1'b1; bus.rxCRCvalid[0] = 1'b1; bus.rxCRCpass[0] = 1'b1;
        tick();
        bus.rxTvalid[0] = 1'b0; bus.rxTlast[0] = 1'b0;
        bus.rxCRCvalid[0] = 1'b0; bus.rxCRCpass[0] = 1'b0;
        check("stale_clear", int'(bus.staleLinks), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cell_comm_link_stats.md
Name: cell_comm_link_stats

Overview:
- Parametrised per-link receive-statistics engine for the cell-communication Aurora links, generalised from fixed CCW/CW to NUM_LINKS links.
- Monitors each link's RX AXIS frame stream and CRC flags, and maintains saturating counters of good frames, CRC faults, length faults and channel-down events.
- Adds a per-link stale-link watchdog.
- Counters are snapshotted atomically into shadow registers on a strobe and read through an indexed, registered mux in the sysClk domain.

Parameters:
- NUM_LINKS, 2, number of monitored links (1..16).
- COUNTER_WIDTH, 16, width of each statistic counter (4..32).
- DATA_WIDTH, 32, readout width; counters are zero-extended (DATA_WIDTH ≥ COUNTER_WIDTH).
- FRAME_WORDS, 16, expected 32-bit words per FA frame, tlast word included.
- TIMEOUT_CYCLES, 125000, sysClk cycles without a completed frame before a link is flagged stale.
- CLEAR_ON_SNAP, 1, 1 = live counters cleared when snapshotted.

Ports:
- sysClk  in  1  system clock; all logic is on this edge.
- sysReset_n  in  1  asynchronous active-low reset, synchronously released upstream.
- rxTvalid  in  NUM_LINKS  per-link RX word valid; already synchronised to sysClk.
- rxTlast  in  NUM_LINKS  per-link last word of frame; qualified by rxTvalid.
- rxCRCvalid  in  NUM_LINKS  CRC result present on this word; qualified by rxTvalid and rxTlast.
- rxCRCpass  in  NUM_LINKS  CRC passed; qualified by rxCRCvalid.
- channelUp  in  NUM_LINKS  per-link Aurora channel up, synchronised.
- snapStrobe  in  1  single-cycle request to copy all live counters to shadow.
- readSel  in  clog2(NUM_LINKS)+2  {link index, counter index}; counter index 0=good, 1=crc, 2=length, 3=linkDown.
- readData  out  DATA_WIDTH  registered shadow value selected by readSel.
- staleLinks  out  NUM_LINKS  per-link stale flag.
- faultSeen  out  NUM_LINKS  sticky: any CRC or length fault since last snapshot.

Behaviour:
- Reset (async assert): all live counters, shadow registers, word counters, watchdogs, readData, staleLinks and faultSeen are 0. Word-counter state for each link is IDLE.
- Per-link frame FSM has three states: IDLE, IN_FRAME and DISCARD.
  - IDLE: on rxTvalid&~rxTlast, set wordCnt=1 and go to IN_FRAME. On rxTvalid&rxTlast, a single-word frame completes.
  - IN_FRAME: each rxTvalid increments wordCnt, which saturates at FRAME_WORDS+1. On rxTlast the frame completes and the FSM returns to IDLE.
  - channelUp=0 in any state: the FSM goes to IDLE and any partial frame is discarded uncounted. While channelUp=0, rxTvalid is ignored.
  - DISCARD: entered from IDLE when channelUp rises mid-stream, i.e. the first valid word is seen within 1 cycle of the rising edge and is not a tlast. Words are dropped until rxTlast, then the FSM returns to IDLE.
- Frame completion (cycle of the tlast word), in priority order:
  1. rxCRCvalid&~rxCRCpass: crc++.
  2. Otherwise, total word count ≠ FRAME_WORDS: length++.
  3. Otherwise: good++.
  - Exactly one counter increments per frame. A frame with rxCRCvalid=0 is judged on length only.
- linkDown++ on each falling edge of channelUp. The previous-value register resets to 0, so there is no spurious count after reset.
- All counters saturate at 2^COUNTER_WIDTH−1 and never wrap.
- faultSeen[i] is set on any crc or length increment and cleared on snapStrobe. A set and a snap in the same cycle leaves it set.
- Watchdog: a per-link counter is cleared on every completed frame or while channelUp=0, and otherwise increments.
  - staleLinks[i]=1 when the counter reaches TIMEOUT_CYCLES. The counter then holds.
  - staleLinks[i] returns to 0 the cycle after the next completed frame or when channelUp=0.
- Snapshot: on snapStrobe, every shadow register takes its live counter's pre-update value in the same cycle.
  - If CLEAR_ON_SNAP=1, a live counter with an increment in the snap cycle becomes 1; otherwise it becomes 0. No event is lost or double-counted.
- Readout: readData updates 1 cycle after readSel and shows shadow values only.
  - A link index ≥ NUM_LINKS reads as 0.
  - Reading the same cycle as snapStrobe returns the old shadow; the new value is visible from the following cycle's read.
- No backpressure: this block only observes and never drives tready.

Test Plan:
- NUM_LINKS=2: send 3 frames of 16 words with CRC pass on link 1, then snap; readSel={1,0} → 3 after 1 cycle, all other counters 0, faultSeen=00.
- Link 0: one frame with rxCRCvalid=1, rxCRCpass=0, one 15-word frame and one 17-word frame, then snap → crc=1, length=2, good=0, faultSeen[0]=1; after a second snap, faultSeen[0]=0.
- Drop channelUp[0] mid-frame (word 8) for 5 cycles, then resume with a full frame → linkDown=1, length=0, good=1.
- Assert snapStrobe in the same cycle as link 1's good-frame tlast, with prior good=4 and CLEAR_ON_SNAP=1 → shadow good=4, next snap reads 1.
- COUNTER_WIDTH=4: send 20 CRC-fail frames → crc reads 15 with no wrap.
- TIMEOUT_CYCLES=100, channelUp=1, no traffic → staleLinks[0] rises at cycle 100; one good frame clears it the cycle after; assert sysReset_n mid-frame → all outputs 0 immediately.
